// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP transmit/receive logic.
package ssp_pkg;

    // Default word width; also the number of data bits per frame.
    localparam int unsigned SSP_DATA_W   = 8;
    localparam int unsigned SSP_BITCNT_W = $clog2(SSP_DATA_W);

    typedef enum logic [1:0] {
        SSP_TX_IDLE  = 2'd0,
        SSP_TX_SYNC  = 2'd1,
        SSP_TX_SHIFT = 2'd2
    } ssp_tx_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned ssp_cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ssp_tx_logic_if.sv
// TxFIFO-to-serializer handshake: head-of-FIFO word, non-empty flag and pop pulse.
interface ssp_tx_logic_if
    import ssp_pkg::*;
#(
    parameter int unsigned DATA_W = SSP_DATA_W
) ();

    logic [DATA_W-1:0] TX_DATA;
    logic              TX_READY;
    logic              TX_READ;

    // FIFO side
    modport master (
        output TX_DATA,
        output TX_READY,
        input  TX_READ
    );

    // Serializer side
    modport slave (
        input  TX_DATA,
        input  TX_READY,
        output TX_READ
    );

endinterface

// File: rtl/ssp_clk_div.sv
// Serial clock divider: SSPCLKOUT = PCLK / (2*HALF_DIV), plus one-cycle
// strobes on the PCLK cycle before each SSPCLKOUT edge.
module ssp_clk_div
    import ssp_pkg::*;
#(
    parameter int unsigned HALF_DIV = 1
) (
    input  logic PCLK,
    input  logic CLEAR_B,
    output logic SSPCLKOUT,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned    CNT_W   = ssp_cnt_w(HALF_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             clk_q;
    logic             toggle;

    // Half-period counter; toggle marks the last cycle of each half period
    always_comb begin
        toggle    = (div_cnt_q == CNT_MAX);
        div_cnt_d = toggle ? '0 : div_cnt_q + CNT_W'(1);
    end

    // Counter and serial clock registers
    always_ff @(posedge PCLK or posedge CLEAR_B) begin
        if (CLEAR_B) begin
            div_cnt_q <= '0;
            clk_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            if (toggle) begin
                clk_q <= ~clk_q;
            end
        end
    end

    assign SSPCLKOUT = clk_q;
    // Strobes are combinational so state clocked on them lands with the SSPCLKOUT edge
    assign rise_tick = toggle & ~clk_q;
    assign fall_tick = toggle & clk_q;

endmodule

// File: rtl/ssp_tx_logic.sv
// SSP transmit serializer: pops words from the TxFIFO and sends frames of
// one frame-sync period followed by DATA_W data bits.
// Build option: define SSP_TX_LSB_FIRST_EN to send bits LSB first
// (default is MSB first); frame timing does not change.
module ssp_tx_logic
    import ssp_pkg::*;
#(
    parameter int unsigned DATA_W   = SSP_DATA_W,
    parameter int unsigned HALF_DIV = 1
) (
    input  logic           PCLK,
    input  logic           CLEAR_B,
    ssp_tx_logic_if.slave  fifo,
    output logic           SSPCLKOUT,
    output logic           SSPFSSOUT,
    output logic           SSPTXD,
    output logic           SSPOE_B
);

    // Package width is reused for the default build; other widths derive their own.
    localparam int unsigned BITCNT_W =
        (DATA_W == SSP_DATA_W) ? SSP_BITCNT_W : ssp_cnt_w(DATA_W);

    localparam logic [1:0] IDLE  = SSP_TX_IDLE;
    localparam logic [1:0] SYNC  = SSP_TX_SYNC;
    localparam logic [1:0] SHIFT = SSP_TX_SHIFT;

`ifdef SSP_TX_LSB_FIRST_EN
    localparam int unsigned FIRST_BIT = 0;
    localparam int unsigned NEXT_BIT  = 1;

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
        return v >> 1;
    endfunction
`else
    localparam int unsigned FIRST_BIT = DATA_W - 1;
    localparam int unsigned NEXT_BIT  = DATA_W - 2;

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
        return v << 1;
    endfunction
`endif

    logic                rise_tick;
    logic                fall_tick_unused;

    logic [1:0]          state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic                fss_q, fss_d;
    logic                txd_q, txd_d;
    logic                oe_b_q, oe_b_d;
    logic                read_q, read_d;
    logic                load;

    ssp_clk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_div (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .SSPCLKOUT (SSPCLKOUT),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick_unused)
    );

    // Frame sequencer; advances only on the cycle before SSPCLKOUT rises
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        fss_d    = fss_q;
        txd_d    = txd_q;
        oe_b_d   = oe_b_q;
        read_d   = 1'b0;
        load     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_tick && fifo.TX_READY) begin
                    load = 1'b1;
                end
            end
            SYNC: begin
                if (rise_tick) begin
                    fss_d    = 1'b0;
                    txd_d    = shreg_q[FIRST_BIT];
                    bitcnt_d = BITCNT_W'(DATA_W - 1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (rise_tick) begin
                    if (bitcnt_q != '0) begin
                        shreg_d  = shift_out(shreg_q);
                        txd_d    = shreg_q[NEXT_BIT];
                        bitcnt_d = bitcnt_q - BITCNT_W'(1);
                    end else if (fifo.TX_READY) begin
                        // Chain straight into the next frame with no idle gap
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        oe_b_d  = 1'b1;
                        txd_d   = 1'b0;
                        fss_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                oe_b_d  = 1'b1;
                txd_d   = 1'b0;
                fss_d   = 1'b0;
            end
        endcase

        // Pop and capture happen on the same edge; TX_READ is high the following cycle
        if (load) begin
            shreg_d = fifo.TX_DATA;
            read_d  = 1'b1;
            fss_d   = 1'b1;
            oe_b_d  = 1'b0;
            txd_d   = 1'b0;
            state_d = SYNC;
        end
    end

    // State and output registers; reset drops any word already popped
    always_ff @(posedge PCLK or posedge CLEAR_B) begin
        if (CLEAR_B) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            fss_q    <= 1'b0;
            txd_q    <= 1'b0;
            oe_b_q   <= 1'b1;
            read_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            fss_q    <= fss_d;
            txd_q    <= txd_d;
            oe_b_q   <= oe_b_d;
            read_q   <= read_d;
        end
    end

    assign SSPFSSOUT    = fss_q;
    assign SSPTXD       = txd_q;
    assign SSPOE_B      = oe_b_q;
    assign fifo.TX_READ = read_q;

endmodule

// File: tb/tb_ssp_tx_logic.sv
// Scoreboard bench for ssp_tx_logic: instance 0 uses HALF_DIV=1, instance 1 HALF_DIV=3.
module tb_ssp_tx_logic;
    import ssp_pkg::*;

    logic PCLK = 1'b0;
    logic CLEAR_B;
    always #5 PCLK = ~PCLK;

    ssp_tx_logic_if #(.DATA_W(8)) bus0 ();
    ssp_tx_logic_if #(.DATA_W(8)) bus1 ();

    wire [1:0] sclk;
    wire [1:0] fss;
    wire [1:0] txd;
    wire [1:0] oeb;
    wire [1:0] rd;
    assign rd = {bus1.TX_READ, bus0.TX_READ};

    ssp_tx_logic #(.DATA_W(8), .HALF_DIV(1)) u_dut0 (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .fifo      (bus0),
        .SSPCLKOUT (sclk[0]),
        .SSPFSSOUT (fss[0]),
        .SSPTXD    (txd[0]),
        .SSPOE_B   (oeb[0])
    );

    ssp_tx_logic #(.DATA_W(8), .HALF_DIV(3)) u_dut1 (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .fifo      (bus1),
        .SSPCLKOUT (sclk[1]),
        .SSPFSSOUT (fss[1]),
        .SSPTXD    (txd[1]),
        .SSPOE_B   (oeb[1])
    );

    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    logic [7:0] ex0[$];
    logic [7:0] ex1[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int mstate[2] = '{0, 0};
    int rd_cnt[2] = '{0, 0};
    int rd_t[2]   = '{0, 0};
    int rd_tp[2]  = '{0, 0};
    int b2b[2]    = '{0, 0};

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Word as the monitor assembles it: first transmitted bit lands in bit 7
    function automatic logic [7:0] exp_of(input logic [7:0] w);
        logic [7:0] r;
`ifdef SSP_TX_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[7-i] = w[i];
`else
        r = w;
`endif
        return r;
    endfunction

    task automatic push(input int k, input logic [7:0] w);
        if (k == 0) begin
            fq0.push_back(w);
            ex0.push_back(exp_of(w));
        end else begin
            fq1.push_back(w);
            ex1.push_back(exp_of(w));
        end
    endtask

    // FIFO models: pop on the negedge inside the TX_READ cycle
    initial begin
        bus0.TX_READY = 1'b0;
        bus0.TX_DATA  = 8'h00;
        forever begin
            @(negedge PCLK);
            if (bus0.TX_READ) begin
                check("read_nonempty[0]", int'(fq0.size() != 0), 1);
                if (fq0.size() != 0) void'(fq0.pop_front());
            end
            bus0.TX_READY = (fq0.size() != 0);
            bus0.TX_DATA  = (fq0.size() != 0) ? fq0[0] : 8'h00;
        end
    end

    initial begin
        bus1.TX_READY = 1'b0;
        bus1.TX_DATA  = 8'h00;
        forever begin
            @(negedge PCLK);
            if (bus1.TX_READ) begin
                check("read_nonempty[1]", int'(fq1.size() != 0), 1);
                if (fq1.size() != 0) void'(fq1.pop_front());
            end
            bus1.TX_READY = (fq1.size() != 0);
            bus1.TX_DATA  = (fq1.size() != 0) ? fq1[0] : 8'h00;
        end
    end

    // Frame monitor: 0 wait, 1 in sync, 2 in bits, 3 frame complete
    task automatic monitor(input int k, input int hd);
        int fcnt = 0;
        int ci = 0;
        int bi = 0;
        logic [7:0] word = 8'h00;
        logic [7:0] e;
        logic cur = 1'b0;
        logic hold_ok = 1'b1;
        logic oe_ok = 1'b1;
        logic rd_prev = 1'b0;
        int have;
        forever begin
            @(negedge PCLK);
            if (CLEAR_B) begin
                mstate[k] = 0;
                rd_prev = 1'b0;
                continue;
            end
            if (rd[k]) begin
                check($sformatf("tx_read_single[%0d]", k), int'(rd_prev), 0);
                rd_cnt[k]++;
                rd_tp[k] = rd_t[k];
                rd_t[k] = cyc;
            end
            rd_prev = rd[k];

            if (mstate[k] == 3) begin
                have = (k == 0) ? int'(ex0.size() != 0) : int'(ex1.size() != 0);
                check($sformatf("frame_expected[%0d]", k), have, 1);
                if (have != 0) begin
                    if (k == 0) e = ex0.pop_front();
                    else e = ex1.pop_front();
                    check($sformatf("tx_word[%0d]", k), int'(word), int'(e));
                end
                check($sformatf("bit_hold[%0d]", k), int'(hold_ok), 1);
                check($sformatf("oe_low_in_frame[%0d]", k), int'(oe_ok), 1);
                if (fss[k]) begin
                    b2b[k]++;
                    oe_ok = !oeb[k];
                    fcnt = 1;
                    mstate[k] = 1;
                end else begin
                    check($sformatf("idle_after_frame[%0d]", k), int'({oeb[k], txd[k]}), 2);
                    mstate[k] = 0;
                end
            end else if (mstate[k] == 0) begin
                if (fss[k]) begin
                    fcnt = 1;
                    oe_ok = !oeb[k];
                    mstate[k] = 1;
                end
            end else if (mstate[k] == 1) begin
                if (fss[k]) begin
                    fcnt++;
                    if (oeb[k]) oe_ok = 1'b0;
                end else begin
                    check($sformatf("fss_len[%0d]", k), fcnt, 2 * hd);
                    mstate[k] = 2;
                    ci = 0;
                    bi = 0;
                    word = 8'h00;
                    hold_ok = 1'b1;
                end
            end

            if (mstate[k] == 2) begin
                if (oeb[k]) oe_ok = 1'b0;
                if (fss[k]) hold_ok = 1'b0;
                if (ci == 0) begin
                    cur = txd[k];
                    word = {word[6:0], txd[k]};
                end else if (txd[k] != cur) begin
                    hold_ok = 1'b0;
                end
                ci++;
                if (ci == 2 * hd) begin
                    ci = 0;
                    bi++;
                    if (bi == 8) mstate[k] = 3;
                end
            end
        end
    endtask

    initial monitor(0, 1);
    initial monitor(1, 3);

    task automatic wait_done(input int k);
        int ok = 0;
        for (int i = 0; i < 400 && ok == 0; i++) begin
            @(negedge PCLK);
            #1;
            if (k == 0) ok = int'(ex0.size() == 0 && fq0.size() == 0 && mstate[0] == 0);
            else ok = int'(ex1.size() == 0 && fq1.size() == 0 && mstate[1] == 0);
        end
        check($sformatf("frames_done[%0d]", k), ok, 1);
    endtask

    task automatic check_reset_outputs(input string name, input int k);
        check(name, int'({sclk[k], fss[k], txd[k], oeb[k], rd[k]}), 5'b00010);
    endtask

    initial begin
        int r0;
        int bb;
        int bad;
        int tog_bad;
        int found;
        logic prev;

        CLEAR_B = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        check_reset_outputs("reset_state[0]", 0);
        check_reset_outputs("reset_state[1]", 1);

        // First SSPCLKOUT rise HALF_DIV cycles after release
        CLEAR_B = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("clk_first_rise_hd1", int'(sclk[0]), 1);
        check("clk_low_hd3_a", int'(sclk[1]), 0);
        @(negedge PCLK);
        check("clk_low_hd3_b", int'(sclk[1]), 0);
        @(negedge PCLK);
        check("clk_first_rise_hd3", int'(sclk[1]), 1);

        // Empty FIFO
        bad = 0;
        tog_bad = 0;
        prev = sclk[0];
        repeat (100) begin
            @(negedge PCLK);
            if (rd[0] || !oeb[0] || txd[0]) bad++;
            if (sclk[0] == prev) tog_bad++;
            prev = sclk[0];
        end
        check("empty_fifo_idle", bad, 0);
        check("empty_fifo_clk_toggle", tog_bad, 0);

        // Single word
        r0 = rd_cnt[0];
        push(0, 8'hA5);
        wait_done(0);
        check("read_count_single", rd_cnt[0] - r0, 1);

        // Back-to-back
        r0 = rd_cnt[0];
        bb = b2b[0];
        push(0, 8'h3C);
        push(0, 8'hC3);
        wait_done(0);
        check("read_count_b2b", rd_cnt[0] - r0, 2);
        check("b2b_no_gap", b2b[0] - bb, 1);
        check("b2b_read_spacing", rd_t[0] - rd_tp[0], 18);

        // Bit-order word
        push(0, 8'h01);
        wait_done(0);

        // HALF_DIV=3
        r0 = rd_cnt[1];
        push(1, 8'h81);
        wait_done(1);
        check("read_count_hd3", rd_cnt[1] - r0, 1);

        // Reset mid-frame: the popped word is discarded, no expectation queued
        r0 = rd_cnt[0];
        fq0.push_back(8'hFF);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge PCLK);
            if (fss[0]) found = 1;
        end
        check("ff_frame_started", found, 1);
        repeat (10) @(negedge PCLK);
        check("ff_frame_active", int'(oeb[0]), 0);
        @(posedge PCLK);
        #2;
        CLEAR_B = 1'b1;
        #1;
        check_reset_outputs("async_reset_mid_frame", 0);
        repeat (3) @(posedge PCLK);
        #1;
        CLEAR_B = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge PCLK);
            if (rd[0] || !oeb[0] || fss[0] || txd[0]) bad++;
        end
        check("no_frame_after_reset", bad, 0);
        check("read_count_reset", rd_cnt[0] - r0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
